// File: rtl/window_button_decoder.sv
// window_button_decoder
//   Input conditioning for the car window controller. Synchronises the raw
//   up/down/limit contacts, debounces the two buttons, classifies presses as
//   manual or auto (long press) and drives a registered 3-bit command word.
//
// Parameters
//   DEBOUNCE_CYCLES      consecutive stable cycles before a debounced level flips
//   LONG_PRESS_CYCLES    hold length at or above which a release enters auto mode
//   AUTO_TIMEOUT_CYCLES  cycles an auto command stays asserted
//   CNT_W                width of the hold and auto counters
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   btn_up    in   raw up switch (async, bouncy)
//   btn_down  in   raw down switch (async, bouncy)
//   limit     in   raw end-stop switch (async)
//   i[2:0]    out  {auto, down, up}; up and down are never high together
//
// Build option
//   WINDOW_AUTO_EN  when defined, long-press auto mode is compiled in; when
//                   undefined, releases always return to IDLE and i[2] is 0.

module window_button_decoder #(
    parameter int DEBOUNCE_CYCLES     = 16,
    parameter int LONG_PRESS_CYCLES   = 1000,
    parameter int AUTO_TIMEOUT_CYCLES = 4000,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       limit,
    output logic [2:0] i
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 ||
        CNT_W < $clog2(LONG_PRESS_CYCLES + 1) ||
        CNT_W < $clog2(AUTO_TIMEOUT_CYCLES)) begin : g_param_check
        $error("window_button_decoder: invalid DEBOUNCE_CYCLES or CNT_W too narrow");
    end

    // ------------------------------------------------------------------
    // 2-flop synchronisers: bit 0 up, bit 1 down, bit 2 limit
    // ------------------------------------------------------------------
    logic [2:0] sync1;
    logic [2:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {limit, btn_down, btn_up};
            sync2 <= sync1;
        end
    end

    logic s_lim;
    assign s_lim = sync2[2];

    // ------------------------------------------------------------------
    // Debounce: counter runs only while the synchronised level differs from
    // the debounced level; the DEBOUNCE_CYCLES-th differing cycle flips it.
    // ------------------------------------------------------------------
    function automatic logic [DB_W:0] db_step(input logic lvl,
                                              input logic cur,
                                              input logic [DB_W-1:0] cnt);
        logic [DB_W:0] r;
        if (lvl == cur)
            r = {cur, {DB_W{1'b0}}};
        else if (cnt == DB_LAST)
            r = {~cur, {DB_W{1'b0}}};
        else
            r = {cur, cnt + 1'b1};
        return r;
    endfunction

    logic            deb_up;
    logic            deb_dn;
    logic [DB_W-1:0] db_cnt_up;
    logic [DB_W-1:0] db_cnt_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_up    <= 1'b0;
            deb_dn    <= 1'b0;
            db_cnt_up <= '0;
            db_cnt_dn <= '0;
        end else begin
            {deb_up, db_cnt_up} <= db_step(sync2[0], deb_up, db_cnt_up);
            {deb_dn, db_cnt_dn} <= db_step(sync2[1], deb_dn, db_cnt_dn);
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
`ifdef WINDOW_AUTO_EN
    typedef enum logic [2:0] {
        IDLE, MAN_UP, MAN_DOWN, AUTO_UP, AUTO_DOWN, LOCKOUT
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TH   = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic [CNT_W-1:0] auto_cnt, auto_n;
    logic             deb_up_q, deb_dn_q;
    logic             press_rise;

    // A fresh debounced press (either button) cancels auto mode.
    assign press_rise = (deb_up & ~deb_up_q) | (deb_dn & ~deb_dn_q);
`else
    typedef enum logic [1:0] {
        IDLE, MAN_UP, MAN_DOWN, LOCKOUT
    } state_t;
`endif

    state_t     state, state_n;
    logic [2:0] i_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
`ifdef WINDOW_AUTO_EN
            hold_cnt <= '0;
            auto_cnt <= '0;
            deb_up_q <= 1'b0;
            deb_dn_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            i        <= i_n;
`ifdef WINDOW_AUTO_EN
            hold_cnt <= hold_n;
            auto_cnt <= auto_n;
            deb_up_q <= deb_up;
            deb_dn_q <= deb_dn;
`endif
        end
    end

    always_comb begin
        state_n = state;
`ifdef WINDOW_AUTO_EN
        hold_n  = hold_cnt;
        auto_n  = auto_cnt;
`endif
        case (state)
            IDLE: begin
                if (deb_up && deb_dn) begin
                    state_n = LOCKOUT;
                end else if (deb_up) begin
                    state_n = MAN_UP;
`ifdef WINDOW_AUTO_EN
                    hold_n  = '0;
`endif
                end else if (deb_dn) begin
                    state_n = MAN_DOWN;
`ifdef WINDOW_AUTO_EN
                    hold_n  = '0;
`endif
                end
            end
            MAN_UP, MAN_DOWN: begin
`ifdef WINDOW_AUTO_EN
                hold_n = (hold_cnt >= LONG_TH) ? hold_cnt : hold_cnt + 1'b1;
`endif
                if (s_lim) begin
                    state_n = LOCKOUT;
                end else if ((state == MAN_UP) ? deb_dn : deb_up) begin
                    state_n = LOCKOUT;
                end else if ((state == MAN_UP) ? !deb_up : !deb_dn) begin
                    state_n = IDLE;
`ifdef WINDOW_AUTO_EN
                    if (hold_cnt >= LONG_TH) begin
                        state_n = (state == MAN_UP) ? AUTO_UP : AUTO_DOWN;
                        auto_n  = '0;
                    end
`endif
                end
            end
`ifdef WINDOW_AUTO_EN
            AUTO_UP, AUTO_DOWN: begin
                auto_n = auto_cnt + 1'b1;
                if (s_lim || press_rise)
                    state_n = LOCKOUT;
                else if (auto_cnt == AUTO_LAST)
                    state_n = IDLE;
            end
`endif
            LOCKOUT: begin
                if (!deb_up && !deb_dn)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Output is decoded from the next state and registered with it, so
        // i changes on the same edge as the state and never glitches.
        i_n = '0;
        case (state_n)
            MAN_UP:    i_n = 3'b001;
            MAN_DOWN:  i_n = 3'b010;
`ifdef WINDOW_AUTO_EN
            AUTO_UP:   i_n = 3'b101;
            AUTO_DOWN: i_n = 3'b110;
`endif
            default:   i_n = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_window_button_decoder.sv
// Directed self-checking bench for window_button_decoder with
// DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, AUTO_TIMEOUT_CYCLES=50.
// Inputs change 1 time unit after a rising edge; i is sampled at that point.
// Auto-mode scenarios apply when WINDOW_AUTO_EN is defined.

module tb_window_button_decoder;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       limit;
    logic [2:0] i;

    int checks = 0;
    int errors = 0;

    window_button_decoder #(
        .DEBOUNCE_CYCLES    (4),
        .LONG_PRESS_CYCLES  (20),
        .AUTO_TIMEOUT_CYCLES(50),
        .CNT_W              (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .limit   (limit),
        .i       (i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [2:0] exp, input string tag);
        checks++;
        assert (i === exp) else begin
            errors++;
            $error("FAIL %s: i=%b expected %b at t=%0t", tag, i, exp, $time);
        end
    endtask

    // Advance n edges, checking i after each one.
    task automatic run(input logic [2:0] exp, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            tick();
            check(exp, tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] bounce;

        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        limit    = 1'b0;
        #2;
        check(3'b000, "reset");
        tick();
        tick();
        rst = 1'b0;
        run(3'b000, 3, "idle");

        // Short up press: 000 through edge 6, 001 at edge 7, release lag 7.
        btn_up = 1'b1;
        run(3'b000, 6, "up_debounce");
        run(3'b001, 1, "up_edge7");
        run(3'b001, 3, "up_hold");
        btn_up = 1'b0;
        run(3'b001, 6, "up_release_lag");
        run(3'b000, 1, "up_off");
        run(3'b000, 3, "idle_after_up");

        // Bounce: high 3, low 2, high 3, low; never debounced.
        bounce = 9'b0_1110_0111;
        for (int k = 0; k < 9; k++) begin
            btn_up = bounce[k];
            tick();
            check(3'b000, "bounce");
        end
        run(3'b000, 8, "bounce_tail");

        // Long down press (30 cycles).
        btn_down = 1'b1;
        run(3'b000, 6, "dn_debounce");
        run(3'b010, 24, "dn_hold");
        btn_down = 1'b0;
        run(3'b010, 6, "dn_release_lag");
`ifdef WINDOW_AUTO_EN
        run(3'b110, 50, "auto_down");
`endif
        run(3'b000, 3, "after_dn");

        // Opposite button in MAN_DOWN locks out until both are released.
        btn_down = 1'b1;
        run(3'b000, 6, "mdn_debounce");
        run(3'b010, 1, "mdn_on");
        btn_up = 1'b1;
        run(3'b010, 6, "mdn_up_lag");
        run(3'b000, 6, "mdn_lockout");
        btn_down = 1'b0;
        run(3'b000, 8, "lockout_up_held");
        btn_up = 1'b0;
        run(3'b000, 8, "lockout_exit");
        btn_down = 1'b1;
        run(3'b000, 6, "idle_probe_deb");
        run(3'b010, 1, "idle_probe_on");
        btn_down = 1'b0;
        run(3'b010, 6, "idle_probe_lag");
        run(3'b000, 2, "idle_probe_off");

        // Limit during MAN_UP: 000 on the 3rd edge.
        btn_up = 1'b1;
        run(3'b000, 6, "mup_debounce");
        run(3'b001, 1, "mup_on");
        limit = 1'b1;
        run(3'b001, 2, "mup_lim_lag");
        run(3'b000, 1, "mup_lim_3rd");
        limit = 1'b0;
        run(3'b000, 5, "mup_lim_lockout");
        btn_up = 1'b0;
        run(3'b000, 10, "mup_lim_release");

        // Both buttons together from IDLE never produce a command.
        btn_up   = 1'b1;
        btn_down = 1'b1;
        run(3'b000, 20, "both_held");
        btn_up   = 1'b0;
        btn_down = 1'b0;
        run(3'b000, 10, "both_released");

        // Reset while MAN_UP with the button still held: async clear, then
        // the held button is re-debounced from zero.
        btn_up = 1'b1;
        run(3'b000, 6, "rst_man_deb");
        run(3'b001, 2, "rst_man_on");
        #3 rst = 1'b1;
        #1 check(3'b000, "rst_async_man");
        tick();
        check(3'b000, "rst_held_man");
        rst = 1'b0;
        run(3'b000, 6, "rst_rebounce");
        run(3'b001, 1, "rst_rebounce_on");
        btn_up = 1'b0;
        run(3'b001, 6, "rst_man_release_lag");
        run(3'b000, 3, "rst_man_off");

`ifdef WINDOW_AUTO_EN
        // In AUTO_DOWN, pressing up cancels; IDLE only after up released.
        btn_down = 1'b1;
        run(3'b000, 6, "ad_debounce");
        run(3'b010, 24, "ad_hold");
        btn_down = 1'b0;
        run(3'b010, 6, "ad_release_lag");
        run(3'b110, 1, "ad_enter");
        btn_up = 1'b1;
        run(3'b110, 6, "ad_cancel_lag");
        run(3'b000, 9, "ad_cancel");
        btn_up = 1'b0;
        run(3'b000, 10, "ad_cancel_release");
        btn_down = 1'b1;
        run(3'b000, 6, "ad_idle_probe_deb");
        run(3'b010, 1, "ad_idle_probe_on");
        btn_down = 1'b0;
        run(3'b010, 6, "ad_idle_probe_lag");
        run(3'b000, 2, "ad_idle_probe_off");

        // In AUTO_UP, limit forces 000 on the 3rd edge.
        btn_up = 1'b1;
        run(3'b000, 6, "au_debounce");
        run(3'b001, 24, "au_hold");
        btn_up = 1'b0;
        run(3'b001, 6, "au_release_lag");
        run(3'b101, 1, "au_enter");
        limit = 1'b1;
        run(3'b101, 2, "au_lim_lag");
        run(3'b000, 1, "au_lim_3rd");
        limit = 1'b0;
        run(3'b000, 6, "au_lim_after");

        // Reset while AUTO_UP clears i without a clock edge.
        btn_up = 1'b1;
        run(3'b000, 6, "ar_debounce");
        run(3'b001, 24, "ar_hold");
        btn_up = 1'b0;
        run(3'b001, 6, "ar_release_lag");
        run(3'b101, 3, "ar_auto");
        #3 rst = 1'b1;
        #1 check(3'b000, "rst_async_auto");
        tick();
        rst = 1'b0;
        run(3'b000, 10, "ar_post_rst");
        btn_up = 1'b1;
        run(3'b000, 6, "ar_new_deb");
        run(3'b001, 1, "ar_new_on");
        btn_up = 1'b0;
        run(3'b001, 6, "ar_new_lag");
        run(3'b000, 2, "ar_new_off");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
